// File: rtl/mig_pkg.sv
// rtl/mig_pkg.sv - shared types and constants for the majority-inverter graph evaluator
package mig_pkg;

  localparam int DEF_NUM_PI    = 8;
  localparam int DEF_MAX_NODES = 64;
  localparam int DEF_IDX_W     = 7;
  localparam int CONST0_IDX    = 0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE,
    ERR
  } state_t;

  function automatic int first_node_idx(input int num_pi);
    return num_pi + 1;
  endfunction

endpackage

// File: rtl/mig_maj3.sv
// rtl/mig_maj3.sv - three-input majority with per-input complement
module mig_maj3 (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic [2:0] inv,
  output logic       y
);

  logic xa, xb, xc;

  assign xa = a ^ inv[0];
  assign xb = b ^ inv[1];
  assign xc = c ^ inv[2];
  assign y  = (xa & xb) | (xa & xc) | (xb & xc);

endmodule

// File: rtl/mig_eval.sv
// rtl/mig_eval.sv - streams a majority-inverter netlist one node per cycle and evaluates its output
module mig_eval
  import mig_pkg::*;
#(
  parameter int NUM_PI    = DEF_NUM_PI,
  parameter int MAX_NODES = DEF_MAX_NODES,
  parameter int IDX_W     = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_PI-1:0] pi,
  input  logic              node_valid,
  output logic              node_ready,
  input  logic [IDX_W-1:0]  node_a,
  input  logic [IDX_W-1:0]  node_b,
  input  logic [IDX_W-1:0]  node_c,
  input  logic [2:0]        node_inv,
  input  logic              node_last,
  input  logic              node_out_inv,
  output logic              busy,
  output logic              po_valid,
  output logic              po,
  output logic              err
);

  localparam int TOTAL = 1 + NUM_PI + MAX_NODES;
  localparam int SPACE = 2 ** IDX_W;
  localparam int FIRST = first_node_idx(NUM_PI);
  localparam int CNT_W = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;

  state_t state, state_nx;

  logic [NUM_PI-1:0]    pi_q;
  logic [MAX_NODES-1:0] node_vals;
  logic [TOTAL-1:0]     vals;
  logic [SPACE-1:0]     vals_ext;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     self_idx;
  logic                 value;
  logic                 accept;
  logic                 fwd_err;
  logic                 overflow;

  // Bit CONST0_IDX is the hard-wired constant-0 signal; unused index space reads as 0.
  assign vals     = {node_vals, pi_q, 1'b0};
  assign vals_ext = SPACE'(vals);

  assign self_idx = IDX_W'(FIRST) + IDX_W'(cnt);
  assign fwd_err  = (node_a >= self_idx) | (node_b >= self_idx) | (node_c >= self_idx);
  assign overflow = (cnt == CNT_W'(MAX_NODES - 1)) && !node_last;
  assign accept   = node_valid && node_ready;

  mig_maj3 u_maj3 (
    .a   (vals_ext[node_a]),
    .b   (vals_ext[node_b]),
    .c   (vals_ext[node_c]),
    .inv (node_inv),
    .y   (value)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      po    <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        cnt <= '0;
      end else if (accept && !fwd_err) begin
        cnt <= cnt + 1'b1;
        if (node_last) po <= value ^ node_out_inv;
      end
    end
  end

  // Netlist storage carries no reset: a new evaluation always rewrites before reading.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) pi_q <= pi;
    if (accept && !fwd_err) node_vals[cnt] <= value;
  end

  always_comb begin
    state_nx   = state;
    node_ready = 1'b0;
    busy       = 1'b1;
    po_valid   = 1'b0;
    err        = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        node_ready = 1'b1;
        if (node_valid) begin
          if (fwd_err)        state_nx = ERR;
          else if (node_last) state_nx = DONE;
          else if (overflow)  state_nx = ERR;
        end
      end
      DONE: begin
        po_valid = 1'b1;
        state_nx = IDLE;
      end
      ERR: begin
        err      = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mig_eval.sv
// tb/tb_mig_eval.sv - vector table, directed corner sequences and randomized netlists against a signal-array model
module tb_mig_eval;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] pi;
  logic       node_valid;
  logic       node_ready;
  logic [6:0] node_a, node_b, node_c;
  logic [2:0] node_inv;
  logic       node_last;
  logic       node_out_inv;
  logic       busy, po_valid, po, err;

  mig_eval dut (
    .clk(clk), .rst(rst), .start(start), .pi(pi),
    .node_valid(node_valid), .node_ready(node_ready),
    .node_a(node_a), .node_b(node_b), .node_c(node_c),
    .node_inv(node_inv), .node_last(node_last), .node_out_inv(node_out_inv),
    .busy(busy), .po_valid(po_valid), .po(po), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pi;
    logic [6:0] a, b, c;
    logic [2:0] inv;
    logic       oinv;
    logic       exp_po;
    logic       exp_err;
  } vec_t;

  int passed = 0;
  int total  = 0;

  logic [6:0] qa[$], qb[$], qc[$];
  logic [2:0] qi[$];
  logic       ql[$], qo[$];
  logic       mpo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_net();
    qa.delete(); qb.delete(); qc.delete(); qi.delete(); ql.delete(); qo.delete();
  endtask

  task automatic push_node(input int a, input int b, input int c, input logic [2:0] inv,
                           input logic last, input logic oinv);
    qa.push_back(7'(a)); qb.push_back(7'(b)); qc.push_back(7'(c));
    qi.push_back(inv); ql.push_back(last); qo.push_back(oinv);
  endtask

  // Signal-array model: evaluates the netlist by index, updating mpo only on success.
  task automatic model_run(input logic [7:0] p, output bit exp_err, output int exp_cnt);
    bit v[0:127];
    v = '{default: 1'b0};
    for (int i = 0; i < 8; i++) v[i + 1] = p[i];
    exp_err = 1'b0;
    exp_cnt = 0;
    for (int k = 0; k < qa.size(); k++) begin
      int idx, ones;
      idx = 9 + k;
      exp_cnt = k + 1;
      if (qa[k] >= idx || qb[k] >= idx || qc[k] >= idx) begin
        exp_err = 1'b1;
        return;
      end
      ones = 0;
      if (v[qa[k]] != qi[k][0]) ones++;
      if (v[qb[k]] != qi[k][1]) ones++;
      if (v[qc[k]] != qi[k][2]) ones++;
      v[idx] = (ones >= 2);
      if (ql[k]) begin
        mpo = v[idx] ^ qo[k];
        return;
      end
      if (k == 63) begin
        exp_err = 1'b1;
        return;
      end
    end
  endtask

  task automatic dut_run(input string name, input logic [7:0] p, input bit noisy,
                         output bit got_done, output bit got_err, output int sent, output bit late);
    got_done = 1'b0; got_err = 1'b0; sent = 0; late = 1'b0;
    @(negedge clk);
    start = 1'b1; pi = p;
    @(negedge clk);
    start = 1'b0; pi = 8'($urandom);
    chk({name, "_load_flags"}, {30'b0, node_ready, busy}, 32'h3);
    for (int k = 0; k < qa.size(); k++) begin
      node_valid = 1'b1;
      node_a = qa[k]; node_b = qb[k]; node_c = qc[k];
      node_inv = qi[k]; node_last = ql[k]; node_out_inv = qo[k];
      if (noisy) begin
        start = 1'($urandom);
        pi    = 8'($urandom);
      end
      @(negedge clk);
      sent++;
      if (po_valid || err) begin
        got_done = po_valid; got_err = err;
        break;
      end
    end
    node_valid = 1'b0; start = 1'b0;
    if (!(got_done || got_err)) begin
      for (int w = 0; w < 4 && !(po_valid || err); w++) @(negedge clk);
      got_done = po_valid; got_err = err;
      late = 1'b1;
    end
  endtask

  task automatic eval_check(input string name, input logic [7:0] p, input bit noisy,
                            input bit exp_err, input int exp_cnt, input logic exp_po);
    bit got_done, got_err, late;
    int sent;
    dut_run(name, p, noisy, got_done, got_err, sent, late);
    chk({name, "_kind"}, {30'b0, got_done, got_err}, {30'b0, !exp_err, exp_err});
    chk({name, "_accepted"}, 32'(sent), 32'(exp_cnt));
    chk({name, "_latency"}, {31'b0, late}, 32'h0);
    chk({name, "_po"}, {31'b0, po}, {31'b0, exp_po});
    @(negedge clk);
    chk({name, "_pulse_end"}, {29'b0, po_valid, err, busy}, 32'h0);
  endtask

  task automatic model_eval(input string name, input logic [7:0] p, input bit noisy);
    bit e;
    int n;
    model_run(p, e, n);
    eval_check(name, p, noisy, e, n, mpo);
  endtask

  task automatic gen_net(input int n, input bit last_at_end, input int fwd_odds);
    clear_net();
    for (int k = 0; k < n; k++) begin
      int idx;
      int ops[3];
      idx = 9 + k;
      for (int j = 0; j < 3; j++)
        ops[j] = (fwd_odds > 0 && $urandom_range(0, fwd_odds - 1) == 0)
                 ? idx + int'($urandom_range(0, 3)) : int'($urandom_range(0, idx - 1));
      push_node(ops[0], ops[1], ops[2], 3'($urandom), last_at_end && (k == n - 1), 1'($urandom));
    end
  endtask

  vec_t vecs[10];

  initial begin
    rst = 1'b1; start = 1'b0; pi = '0; node_valid = 1'b0;
    node_a = '0; node_b = '0; node_c = '0; node_inv = '0; node_last = 1'b0; node_out_inv = 1'b0;
    mpo = 1'b0;

    vecs[0] = '{8'h06, 7'd2, 7'd3,   7'd0, 3'b000, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h02, 7'd2, 7'd3,   7'd0, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 7'd2, 7'd3,   7'd0, 3'b100, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h04, 7'd2, 7'd3,   7'd0, 3'b100, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 7'd9, 7'd1,   7'd1, 3'b000, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 7'd0, 7'd0,   7'd0, 3'b111, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 7'd8, 7'd8,   7'd0, 3'b000, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h55, 7'd1, 7'd3,   7'd5, 3'b000, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{8'h00, 7'd1, 7'd127, 7'd2, 3'b000, 1'b0, 1'b1, 1'b1};
    vecs[9] = '{8'hAA, 7'd1, 7'd3,   7'd5, 3'b000, 1'b0, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset_outputs", {27'b0, node_ready, busy, po_valid, po, err}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {27'b0, node_ready, busy, po_valid, po, err}, 32'h0);

    for (int i = 0; i < 10; i++) begin
      clear_net();
      push_node(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].inv, 1'b1, vecs[i].oinv);
      eval_check($sformatf("vec%0d", i), vecs[i].pi, 1'b0, vecs[i].exp_err, 1, vecs[i].exp_po);
      mpo = vecs[i].exp_po;
    end

    clear_net();
    push_node(1, 2, 0, 3'b000, 1'b0, 1'b0);
    push_node(9, 3, 4, 3'b000, 1'b0, 1'b0);
    push_node(10, 5, 0, 3'b001, 1'b1, 1'b1);
    eval_check("chain", 8'h1F, 1'b1, 1'b0, 3, 1'b1);
    mpo = 1'b1;

    clear_net();
    push_node(9, 2, 3, 3'b000, 1'b1, 1'b0);
    eval_check("fwd_ref", 8'h00, 1'b0, 1'b1, 1, 1'b1);

    gen_net(64, 1'b0, 0);
    model_eval("overflow", 8'($urandom), 1'b1);
    gen_net(64, 1'b1, 0);
    model_eval("full_last", 8'($urandom), 1'b1);

    @(negedge clk);
    start = 1'b1; pi = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      node_valid = 1'b1; node_a = 7'(k + 1); node_b = 7'd2; node_c = 7'd0;
      node_inv = 3'b000; node_last = 1'b0; node_out_inv = 1'b0;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; node_valid = 1'b0;
    chk("mid_load_reset", {27'b0, node_ready, busy, po_valid, po, err}, 32'h0);
    mpo = 1'b0;
    clear_net();
    push_node(1, 2, 0, 3'b000, 1'b0, 1'b0);
    push_node(9, 3, 4, 3'b000, 1'b0, 1'b0);
    push_node(10, 5, 0, 3'b001, 1'b1, 1'b1);
    model_eval("post_reset", 8'h1F, 1'b0);

    for (int t = 0; t < 40; t++) begin
      gen_net(int'($urandom_range(1, 12)), 1'b1, (t % 3 == 0) ? 12 : 0);
      model_eval($sformatf("rand%0d", t), 8'($urandom), 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
